// File: rtl/brentkung_share_pkg.sv
// Shared types and helpers for the Brent-Kung adder sharing controller.
// W is fixed at 12 to match the shared adder instance.
package brentkung_share_pkg;

  localparam int W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // The adder takes its operands bit-interleaved: even bits carry A, odd bits carry B.
  function automatic logic [2*W-1:0] interleave(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] bus;
    bus = '0;
    for (int k = 0; k < W; k++) begin
      bus[2*k]   = a[k];
      bus[2*k+1] = b[k];
    end
    return bus;
  endfunction

endpackage

// File: rtl/brentkung_share_ctrl_arbiter.sv
// One-hot request arbiter for the shared adder.
// Round-robin when ARB_RR_EN is defined, otherwise fixed priority (lowest index wins).
module share_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
`ifdef ARB_RR_EN
  input  logic            clk,
  input  logic            rst,
  input  logic            advance_i,
`endif
  input  logic [NREQ-1:0] req_valid_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_id_o,
  output logic            any_o
);

  logic [IDW-1:0] base;

`ifdef ARB_RR_EN
  logic [IDW-1:0] ptr_q;

  // The pointer names the highest-priority requester; it moves just past each winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (grant_id_o == IDW'(NREQ - 1)) ? '0 : grant_id_o + IDW'(1);
    end
  end

  assign base = ptr_q;
`else
  assign base = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int             pos;
    logic [IDW-1:0] idx;
    grant_o    = '0;
    grant_id_o = '0;
    pos        = 0;
    idx        = '0;
    // Walk from lowest to highest priority; the last hit is the winner.
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(base) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = IDW'(pos);
      if (req_valid_i[idx]) grant_id_o = idx;
    end
    if (|req_valid_i) grant_o[grant_id_o] = 1'b1;
  end

  assign any_o = |req_valid_i;

endmodule

// File: rtl/brentkung_share_ctrl.sv
// Controller sharing one combinational 12-bit Brent-Kung adder among NREQ requesters.
// Optional round-robin arbitration is enabled with the ARB_RR_EN macro.
module brentkung_share_ctrl
  import brentkung_share_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 12,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [2*W-1:0]    add_in,
  input  logic [W:0]        add_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W:0]        resp_sum,
  output logic [IDW-1:0]    resp_id
);

  if (W != brentkung_share_pkg::W) begin : g_bad_width
    $error("brentkung_share_ctrl: W must be 12 to match the shared adder");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("brentkung_share_ctrl: NREQ must be in 2..8");
  end

  state_e          state_q;
  logic [2*W-1:0]  opnd_q;
  logic [IDW-1:0]  op_id_q;
  logic [IDW-1:0]  resp_id_q;
  logic [W:0]      sum_q;
  logic            resp_valid_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            any_req;
  logic            can_accept;
  logic            accept;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;

  share_arbiter #(.NREQ(NREQ)) u_arb (
`ifdef ARB_RR_EN
    .clk         (clk),
    .rst         (rst),
    .advance_i   (accept),
`endif
    .req_valid_i (req_valid),
    .grant_o     (grant),
    .grant_id_o  (grant_id),
    .any_o       (any_req)
  );

  // Grants are also suppressed while rst is high so req_ready drops with the async reset.
  assign can_accept = !rst && ((state_q == IDLE) || (state_q == RESP && resp_ready));
  assign accept     = can_accept && any_req;
  assign req_ready  = can_accept ? grant : '0;

  assign a_sel = req_a[int'(grant_id)*W +: W];
  assign b_sel = req_b[int'(grant_id)*W +: W];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      opnd_q       <= '0;
      op_id_q      <= '0;
      resp_id_q    <= '0;
      sum_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      // Operands only change on accept, so the adder input is quiet while idle.
      if (accept) begin
        opnd_q  <= interleave(a_sel, b_sel);
        op_id_q <= grant_id;
      end
      case (state_q)
        IDLE: if (accept) state_q <= EXEC;
        EXEC: begin
          sum_q        <= add_out;
          resp_id_q    <= op_id_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          state_q      <= accept ? EXEC : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign add_in     = opnd_q;
  assign resp_valid = resp_valid_q;
  assign resp_sum   = sum_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_brentkung_share_ctrl.sv
// Self-checking bench for brentkung_share_ctrl: directed scenarios plus a randomized
// transaction-level scoreboard. Honours ARB_RR_EN to pick the expected arbitration order.
module tb_brentkung_share_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam int IDW  = $clog2(NREQ);

  typedef struct {
    int        id;
    logic [W:0] sum;
    int        due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [2*W-1:0]    add_in;
  logic [W:0]        add_out;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [W:0]        resp_sum;
  logic [IDW-1:0]    resp_id;

  logic [W-1:0] a_r [NREQ];
  logic [W-1:0] b_r [NREQ];

  int n_cmp = 0;
  int n_bad = 0;

  exp_t            exp_q[$];
  int              rr_ptr     = 0;
  logic [2*W-1:0]  exp_add_in = '0;
  int              cyc        = 0;
  int              n_done     = 0;
  bit              hold_valid = 1'b1;

  logic [NREQ-1:0] obs_acc;
  logic [NREQ-1:0] obs_rdy;
  logic            obs_rv;
  logic [W:0]      obs_sum;
  logic [IDW-1:0]  obs_id;
  int              obs_cyc;

  brentkung_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_in     (add_in),
    .add_out    (add_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = a_r[i];
      req_b[i*W +: W] = b_r[i];
    end
  end

  // Behavioural stand-in for the shared adder: undo the interleave and add.
  always_comb begin
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    xa = '0;
    xb = '0;
    for (int k = 0; k < W; k++) begin
      xa[k] = add_in[2*k];
      xb[k] = add_in[2*k+1];
    end
    add_out = {1'b0, xa} + {1'b0, xb};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [2*W-1:0] il(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) begin
      r[2*k]   = a[k];
      r[2*k+1] = b[k];
    end
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (rr_ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int oh2id(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Per-cycle model step, run at the falling edge.
  task automatic evaluate();
    logic [NREQ-1:0] g;
    int              w;
    bit              rv_exp;
    bit              can_acc;
    obs_acc = req_ready & req_valid;
    obs_rdy = req_ready;
    obs_rv  = resp_valid;
    obs_sum = resp_sum;
    obs_id  = resp_id;
    obs_cyc = cyc;
    g = '0;
    if (rst) begin
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_resp_valid", 32'(resp_valid), 0);
      check("rst_add_in", 32'(add_in), 0);
      exp_q.delete();
      rr_ptr     = 0;
      exp_add_in = '0;
      cyc++;
      return;
    end
    rv_exp = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
    check("resp_valid", 32'(resp_valid), 32'(rv_exp));
    if (rv_exp) begin
      check("resp_sum", 32'(resp_sum), 32'(exp_q[0].sum));
      check("resp_id", 32'(resp_id), 32'(exp_q[0].id));
    end
    check("add_in", 32'(add_in), 32'(exp_add_in));
    can_acc = (exp_q.size() == 0) || (rv_exp && resp_ready);
    w = pick(req_valid);
    if (can_acc && w >= 0) g[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(g));
    if (rv_exp && resp_ready) begin
      void'(exp_q.pop_front());
      n_done++;
    end
    if (g != '0) begin
      exp_q.push_back('{id: w, sum: {1'b0, a_r[w]} + {1'b0, b_r[w]}, due: cyc + 2});
      exp_add_in = il(a_r[w], b_r[w]);
`ifdef ARB_RR_EN
      rr_ptr = (w + 1) % NREQ;
`endif
    end
    cyc++;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
    if (!hold_valid) req_valid = req_valid & ~obs_acc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("async_resp_valid", 32'(resp_valid), 0);
    check("async_req_ready", 32'(req_ready), 0);
    check("async_add_in", 32'(add_in), 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_acc(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (obs_acc == '0 && n < 20);
    check(tag, 32'(obs_acc != '0), 1);
  endtask

  task automatic wait_rv(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!obs_rv && n < 20);
    check(tag, 32'(obs_rv), 1);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !obs_acc[i]) begin
        if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
      end else begin
        req_valid[i] = ($urandom_range(0, 99) < 45);
        if (req_valid[i]) begin
          a_r[i] = rand_opnd();
          b_r[i] = rand_opnd();
        end
      end
    end
    resp_ready = ($urandom_range(0, 99) < 70);
  endtask

  initial begin
    int t0;
    int ids[$];
    int exp_ids[$];
    bit did_mid_reset;
    logic [W:0] s0;

    for (int i = 0; i < NREQ; i++) begin
      a_r[i] = '0;
      b_r[i] = '0;
    end

    // Reset state.
    @(posedge clk);
    #1;
    check("reset_resp_sum", 32'(resp_sum), 0);
    check("reset_resp_id", 32'(resp_id), 0);
    check("reset_resp_valid", 32'(resp_valid), 0);
    check("reset_add_in", 32'(add_in), 0);
    tick();
    rst = 1'b0;

    // Carry-out boundary and two-cycle latency.
    hold_valid = 1'b0;
    a_r[0]     = 12'hFFF;
    b_r[0]     = 12'h001;
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    wait_acc("t2_accept");
    t0 = obs_cyc;
    wait_rv("t2_resp");
    check("t2_latency", 32'(obs_cyc - t0), 2);
    check("t2_sum", 32'(obs_sum), 32'h1000);
    check("t2_id", 32'(obs_id), 0);
    tick();

    // All requesters held valid: arbitration order.
    req_valid = '0;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_r[i] = W'($urandom);
      b_r[i] = W'($urandom);
    end
`ifdef ARB_RR_EN
    exp_ids = '{0, 1, 2, 3, 0};
`else
    exp_ids = '{0, 0, 0};
`endif
    hold_valid = 1'b1;
    resp_ready = 1'b1;
    req_valid  = '1;
    for (int n = 0; n < 40 && ids.size() < exp_ids.size(); n++) begin
      tick();
      if (obs_acc != '0) ids.push_back(oh2id(obs_acc));
    end
    check("t3_count", 32'(ids.size()), 32'(exp_ids.size()));
    foreach (exp_ids[i]) begin
      if (i < ids.size()) check($sformatf("t3_id%0d", i), 32'(ids[i]), 32'(exp_ids[i]));
    end

    // Consumer stalls with req1 pending; then back-to-back accepts.
    req_valid = '0;
    do_reset();
    hold_valid = 1'b0;
    resp_ready = 1'b0;
    a_r[0]     = W'($urandom);
    b_r[0]     = W'($urandom);
    s0         = {1'b0, a_r[0]} + {1'b0, b_r[0]};
    req_valid  = 4'b0001;
    wait_acc("t4_accept0");
    a_r[1]       = W'($urandom);
    b_r[1]       = W'($urandom);
    req_valid[1] = 1'b1;
    wait_rv("t4_resp0");
    for (int n = 0; n < 5; n++) begin
      tick();
      check("t4_hold_sum", 32'(obs_sum), 32'(s0));
      check("t4_hold_id", 32'(obs_id), 0);
      check("t4_hold_ready", 32'(obs_rdy), 0);
      check("t4_hold_valid", 32'(obs_rv), 1);
    end
    resp_ready = 1'b1;
    tick();
    check("t4_b2b_grant", 32'(obs_acc), 32'b0010);
    resp_ready = 1'b0;
    wait_rv("t4_resp1");
    check("t4_sum1", 32'(obs_sum), 32'({1'b0, a_r[1]} + {1'b0, b_r[1]}));
    check("t4_id1", 32'(obs_id), 1);

    a_r[2]     = 12'h800;
    b_r[2]     = 12'h800;
    req_valid  = 4'b0100;
    resp_ready = 1'b1;
    tick();
    check("t5_b2b_grant", 32'(obs_acc), 32'b0100);
    wait_rv("t5_resp");
    check("t5_sum", 32'(obs_sum), 32'h1000);
    check("t5_id", 32'(obs_id), 2);
    tick();

    // Randomized traffic with an asynchronous reset in the middle.
    hold_valid    = 1'b1;
    req_valid     = '0;
    n_done        = 0;
    did_mid_reset = 1'b0;
    for (int c = 0; c < 80000 && n_done < 10000; c++) begin
      rand_inputs();
      if (!did_mid_reset && n_done >= 5000 && resp_valid) begin
        did_mid_reset = 1'b1;
        do_reset();
      end
      tick();
    end
    check("t6_ops_done", 32'(n_done >= 10000), 1);
    check("t1_mid_reset_hit", 32'(did_mid_reset), 1);

    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (6) tick();
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
